// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the ofifo output collection buffer.
package ofifo_pkg;

    localparam int COL_DEF   = 8;
    localparam int BW_DEF    = 16;
    localparam int DEPTH_DEF = 64;

    // One extra bit above the address gives the wrap bit used to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane FIFO: wrap-bit pointers, first-word-fall-through head, unreset storage.
// The caller qualifies wr_i/rd_i; this lane never sees a write it must drop.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic [bw-1:0] din_i,
    output logic [bw-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int PTR_W = ptr_w(depth);
    localparam int AW    = PTR_W - 1;

    logic [bw-1:0]    mem_q [depth];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    // Pointers advance modulo 2*depth through natural overflow of the wrap bit.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_i) wptr_d = wptr_q + 1'b1;
        if (rd_i) rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; the head is masked while the row is not valid.
    always_ff @(posedge clk) begin
        if (wr_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/ofifo.sv
// ofifo: per-column output lanes released as whole rows.
// Optional sticky overflow/underflow flags are built when OFIFO_ERR_CHECK_EN is defined.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col   = COL_DEF,
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready
`ifdef OFIFO_ERR_CHECK_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] lane_wr;
    logic [bw-1:0]  lane_dout [col];
    logic           pop;

    // Flags depend only on lane pointers, so no input reaches them combinationally.
    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full lane may still take a write when the same cycle pops a row out of it.
    assign lane_wr = wr & (~lane_full | {col{pop}});

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(.bw(bw), .depth(depth)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_i    (lane_wr[i]),
            .rd_i    (pop),
            .din_i   (in[bw*i +: bw]),
            .dout_o  (lane_dout[i]),
            .empty_o (lane_empty[i]),
            .full_o  (lane_full[i])
        );
    end

    // Row output: lane heads when a full row is present, otherwise all zeros.
    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int i = 0; i < col; i++) out[bw*i +: bw] = lane_dout[i];
        end
    end

`ifdef OFIFO_ERR_CHECK_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    assign ovf_d = ovf_q | (|(wr & ~lane_wr));
    assign udf_d = udf_q | (rd & ~o_valid);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`endif

endmodule

// File: doc/ofifo.md
# ofifo

Output-side collection buffer for the MAC array: one FIFO lane per array column captures that column's partial sums whenever the column asserts its own valid. Columns complete at staggered cycles. The block releases a full output row only when every lane holds data and the consumer pops all lanes together. It sits between the array's bottom edge and the SRAM write-back path, mirroring the input-side L0 buffer in the opposite direction.

## Interface
- `col`, default 8: number of array columns, one lane each.
- `bw`, default 16: partial-sum width per column.
- `depth`, default 64: entries per lane; must be a power of two and ≥ 2.
- `clk`  input  1: single clock; all state updates on rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `in`  input  col*bw: column data; lane i uses bits `[bw*(i+1)-1 : bw*i]`.
- `wr`  input  col: per-lane write strobe from the array's column valids.
- `rd`  input  1: pop one entry from every lane.
- `out`  output  col*bw: head entry of each lane, same lane packing as `in`.
- `o_valid`  output  1: every lane is non-empty.
- `o_full`  output  1: at least one lane is full.
- `o_ready`  output  1: equals `!o_full`.

## Operation
- Each lane keeps a write pointer and a read pointer, each `$clog2(depth)+1` bits. The MSB is the wrap bit.
  - Lane empty: the pointers are equal.
  - Lane full: the low bits are equal and the wrap bits differ.
- **Write, lane i:** when `wr[i]` is high and lane i is not full, store `in` lane i at `wptr[i]` and increment `wptr[i]` modulo 2·depth.
  - A write to a full lane is dropped; no state changes for that lane.
  - Exception: if the same cycle contains an accepted pop, the write to the full lane is accepted.
- **Pop:** a pop is accepted only when `rd` and `o_valid` are both high. It increments every lane's read pointer together.
  - `rd` while `o_valid` is low is ignored and changes no state.
- **Lane independence:** lanes fill independently; the stagger between columns is absorbed here, and each lane's occupancy may differ.
- **Output:** `out` is first-word-fall-through from each lane's read pointer. When `o_valid` is low, the whole of `out` is driven to 0.
- **Simultaneous write and pop on one lane:** both take effect.
  - Occupancy is unchanged.
  - The popped entry is the old head; the written entry goes to the tail.
  - There is no same-cycle bypass from `in` to `out`.
- **Reset:** asserting `reset_n` low, including mid-operation, immediately sets:
  - all pointers to 0;
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `out`=0.
  - Memory contents are not cleared.

## Timing
- **Write-to-visible latency:** a write in cycle N updates occupancy at edge N+1. `o_valid` can rise in cycle N+1 at the earliest.
- **Pop latency:** a pop in cycle N advances the head at edge N+1. The new `out`/`o_valid` appear in cycle N+1.
- **Flag timing:** `o_valid`, `o_full` and `o_ready` are combinational from the pointer registers only, with no path from `wr`, `rd` or `in`.
- **Sustained throughput:** one row per cycle when all lanes stay non-empty.
- **Back-pressure:** the array must stall when `o_ready` is low; overflow protection is the drop rule above.

## Configuration
- `OFIFO_ERR_CHECK_EN`
  - **Defined:** adds two outputs, `o_overflow` and `o_underflow`, each 1 bit, sticky, and cleared only by reset.
    - `o_overflow` is set by any dropped write.
    - `o_underflow` is set by `rd` while `o_valid` is low.
    - Both flags are registered and assert the cycle after the offending event.
  - **Undefined:** these ports and their logic are absent; all other behaviour is identical.

## Structure
- A shared package holds:
  - the default `col`/`bw`/`depth` constants;
  - the pointer-width function `PTR_W = $clog2(depth)+1`.
- Sub-module `ofifo_lane`: a single-lane FIFO with its own pointers and storage, `empty`/`full` outputs, and `wr`/`rd` inputs.
  - `ofifo` instantiates `col` copies of it.
  - `ofifo` drives the common pop into every lane and ORs/ANDs the lane flags.

## Test plan
- **Reset release, no stimulus:** expect `o_valid`=0, `o_full`=0, `o_ready`=1, `out`=0.
- **Staggered fill:** write lane i in cycle i, i=0..7, with value 0x0100+i.
  - `o_valid` rises in cycle 8.
  - `out` lane i equals 0x0100+i.
  - A pop returns all lanes to empty and `o_valid`=0.
- **Lane 3 overflow:** write 64 entries to lane 3 only.
  - `o_full`=1 and `o_ready`=0.
  - A 65th write is dropped and occupancy stays 64.
  - With the macro defined, `o_overflow`=1.
- **Full lane with concurrent pop:** all lanes full, then `rd`=1 and `wr`=0xFF in the same cycle.
  - Occupancy stays 64.
  - The old head 0 is popped and the new tail is written.
- **Pointer wrap:** stream 200 rows of incrementing data with a concurrent read each cycle.
  - Output order is preserved across pointer wrap with no loss.
- **Misuse and mid-operation reset:**
  - `rd`=1 on empty lanes changes no state; with the macro defined, `o_underflow`=1.
  - `reset_n` pulsed low with lanes half full clears all flags immediately, and `o_valid`=0.
